// File: rtl/mld_pkg.sv
// Shared types, default (15,7) code constants and helpers for the
// cyclic majority-logic ping-pong decoder.
package mld_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY     = 2'd0,
    BANK_LOADING   = 2'd1,
    BANK_FULL      = 2'd2,
    BANK_DECODING  = 2'd3
  } bank_state_t;

  localparam logic [8:0]  DEF_GEN_POLY  = 9'b1_1101_0001;
  localparam logic [31:0] DEF_CHK_MASKS = 32'h4522_0880;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n = 0;
    for (int i = 0; i < 32; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/mld_codeword_bank.sv
// One codeword bank: N-bit receive buffer, R-bit syndrome register,
// bank state and the correction-enable flag latched with the first bit.
module mld_codeword_bank
  import mld_pkg::*;
#(
  parameter int             N        = 15,
  parameter int             K        = 7,
  parameter logic [N-K:0]   GEN_POLY = DEF_GEN_POLY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_load_bit,
  input  logic             i_load_corr,
  input  logic             i_load_last,
  input  logic             i_step,
  input  logic             i_step_last,
  input  logic             i_e,
  output bank_state_t      o_state,
  output logic             o_msb,
  output logic [N-K-1:0]   o_syn,
  output logic [N-K-1:0]   o_syn_next,
  output logic             o_corr
);

  localparam int R = N - K;

  bank_state_t    r_state;
  logic [N-1:0]   r_buf;
  logic [R-1:0]   r_syn;
  logic           r_corr;

  // Multiply by x modulo g(x), then add b at s0.
  function automatic logic [R-1:0] syn_shift(input logic [R-1:0] s, input logic b);
    return {s[R-2:0], b} ^ (s[R-1] ? GEN_POLY[R-1:0] : '0);
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the buffer is a handful of flops, so it is reset with everything else.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= BANK_EMPTY;
      r_buf   <= '0;
      r_syn   <= '0;
      r_corr  <= 1'b0;
    end else if (i_load) begin
      r_buf <= {r_buf[N-2:0], i_load_bit};
      if (r_state == BANK_EMPTY) begin
        r_syn  <= {{(R-1){1'b0}}, i_load_bit};
        r_corr <= i_load_corr;
      end else begin
        r_syn <= syn_shift(r_syn, i_load_bit);
      end
      r_state <= i_load_last ? BANK_FULL : BANK_LOADING;
    end else if (i_step) begin
      r_buf   <= {r_buf[N-2:0], r_buf[N-1]};
      r_syn   <= o_syn_next;
      r_state <= i_step_last ? BANK_EMPTY : BANK_DECODING;
    end
  end

  assign o_state    = r_state;
  assign o_msb      = r_buf[N-1];
  assign o_syn      = r_syn;
  assign o_syn_next = syn_shift(r_syn, i_e);
  assign o_corr     = r_corr;

endmodule

// File: rtl/mld_cyclic_pingpong_decoder.sv
// Type-I one-step majority-logic decoder for cyclic (N,K) codes with two
// ping-pong banks; the majority gate and output register are shared.
module mld_cyclic_pingpong_decoder
  import mld_pkg::*;
#(
  parameter int                   N         = 15,
  parameter int                   K         = 7,
  parameter logic [N-K:0]         GEN_POLY  = DEF_GEN_POLY,
  parameter int                   J         = 4,
  parameter logic [J*(N-K)-1:0]   CHK_MASKS = DEF_CHK_MASKS,
  parameter int                   THRESH    = 3,
  parameter bit                   INFO_ONLY = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic                    in_bit,
  output logic                    in_ready,
  input  logic                    correct_errors,
  output logic                    out_valid,
  output logic                    out_bit,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [$clog2(N+1)-1:0]  err_count,
  output logic                    out_fail
);

  localparam int                R         = N - K;
  localparam int                CW        = $clog2(N + 1);
  localparam int                STEPS     = INFO_ONLY ? K : N;
  localparam logic [CW-1:0]     LAST_BIT  = CW'(N - 1);
  localparam logic [CW-1:0]     LAST_STEP = CW'(STEPS - 1);
  localparam int unsigned       THRESH_U  = THRESH;

  logic           r_load_ptr, r_dec_ptr;
  logic [CW-1:0]  r_load_cnt, r_step, r_err_acc, r_err_pend, r_err_count;
  logic           r_fail_pend, r_out_fail;
  logic           r_out_valid, r_out_bit, r_out_last;

  bank_state_t    w_state    [2];
  logic           w_msb      [2];
  logic [R-1:0]   w_syn      [2];
  logic [R-1:0]   w_syn_next [2];
  logic           w_corr     [2];

  logic           w_in_fire, w_load_last, w_src_avail, w_take, w_step_last, w_e;
  logic [J-1:0]   w_chk;

  assign in_ready    = (w_state[r_load_ptr] == BANK_EMPTY) || (w_state[r_load_ptr] == BANK_LOADING);
  assign w_in_fire   = in_valid && in_ready;
  assign w_load_last = (r_load_cnt == LAST_BIT);
  assign w_src_avail = (w_state[r_dec_ptr] == BANK_FULL) || (w_state[r_dec_ptr] == BANK_DECODING);
  // The output register is refilled whenever it is empty or being consumed.
  assign w_take      = w_src_avail && (!r_out_valid || out_ready);
  assign w_step_last = (r_step == LAST_STEP);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    mld_codeword_bank #(.N(N), .K(K), .GEN_POLY(GEN_POLY)) u_bank (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_in_fire && (r_load_ptr == 1'(b))),
      .i_load_bit  (in_bit),
      .i_load_corr (correct_errors),
      .i_load_last (w_load_last),
      .i_step      (w_take && (r_dec_ptr == 1'(b))),
      .i_step_last (w_step_last),
      .i_e         (w_e),
      .o_state     (w_state[b]),
      .o_msb       (w_msb[b]),
      .o_syn       (w_syn[b]),
      .o_syn_next  (w_syn_next[b]),
      .o_corr      (w_corr[b])
    );
  end

  // NOTE: give every always_comb output a default first so no latch is inferred.
  always_comb begin
    w_chk = '0;
    for (int j = 0; j < J; j++) w_chk[j] = ^(w_syn[r_dec_ptr] & CHK_MASKS[j*R +: R]);
  end

  assign w_e = w_corr[r_dec_ptr] && (popcount(32'(w_chk)) >= THRESH_U);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_load_ptr  <= 1'b0;
      r_dec_ptr   <= 1'b0;
      r_load_cnt  <= '0;
      r_step      <= '0;
      r_err_acc   <= '0;
      r_err_pend  <= '0;
      r_err_count <= '0;
      r_fail_pend <= 1'b0;
      r_out_fail  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_in_fire) begin
        if (w_load_last) begin
          r_load_cnt <= '0;
          r_load_ptr <= ~r_load_ptr;
        end else begin
          r_load_cnt <= r_load_cnt + 1'b1;
        end
      end

      if (w_take) begin
        r_out_valid <= 1'b1;
        r_out_bit   <= w_msb[r_dec_ptr] ^ w_e;
        r_out_last  <= w_step_last;
        if (w_step_last) begin
          r_step      <= '0;
          r_dec_ptr   <= ~r_dec_ptr;
          r_err_acc   <= '0;
          r_err_pend  <= r_err_acc + {{(CW-1){1'b0}}, w_e};
          r_fail_pend <= (INFO_ONLY == 1'b0) && (|w_syn_next[r_dec_ptr]);
        end else begin
          r_step    <= r_step + 1'b1;
          r_err_acc <= r_err_acc + {{(CW-1){1'b0}}, w_e};
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end

      // Per-word status becomes visible only once the sink takes the last bit.
      if (r_out_valid && out_ready && r_out_last) begin
        r_err_count <= r_err_pend;
        r_out_fail  <= r_fail_pend;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_bit   = r_out_bit;
  assign out_last  = r_out_last;
  assign err_count = r_err_count;
  assign out_fail  = r_out_fail;

endmodule

// File: tb/tb_mld_cyclic_pingpong_decoder.sv
// Directed bench for the (15,7) majority-logic decoder: clean, single and
// double errors, pass-through, back-to-back streaming, stalls and reset.
module tb_mld_cyclic_pingpong_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        correct_errors = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, out_bit, out_last, out_fail;
  logic [3:0]  err_count;

  logic        info_in_valid;
  logic        info_in_ready, info_out_valid, info_out_bit, info_out_last, info_out_fail;
  logic [3:0]  info_err_count;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          last_acc = 0;
  int          stall_cnt = 0;

  logic [14:0] mon_word = '0;
  int          mon_bits = 0;
  logic [6:0]  info_word = '0;
  logic [14:0] got_q[$];
  int          len_q[$];
  int          first_cyc_q[$];
  int          last_cyc_q[$];
  logic [6:0]  info_q[$];

  mld_cyclic_pingpong_decoder u_dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_bit         (in_bit),
    .in_ready       (in_ready),
    .correct_errors (correct_errors),
    .out_valid      (out_valid),
    .out_bit        (out_bit),
    .out_last       (out_last),
    .out_ready      (out_ready),
    .err_count      (err_count),
    .out_fail       (out_fail)
  );

  // Second instance sees exactly the bits the main instance accepts.
  assign info_in_valid = in_valid && in_ready;

  mld_cyclic_pingpong_decoder #(.INFO_ONLY(1'b1)) u_info (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (info_in_valid),
    .in_bit         (in_bit),
    .in_ready       (info_in_ready),
    .correct_errors (correct_errors),
    .out_valid      (info_out_valid),
    .out_bit        (info_out_bit),
    .out_last       (info_out_last),
    .out_ready      (1'b1),
    .err_count      (info_err_count),
    .out_fail       (info_out_fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      mon_bits = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (mon_bits == 0) first_cyc_q.push_back(cyc);
        mon_word = {mon_word[13:0], out_bit};
        mon_bits++;
        if (out_last) begin
          got_q.push_back(mon_word);
          len_q.push_back(mon_bits);
          last_cyc_q.push_back(cyc);
          mon_bits = 0;
        end
      end
      if (info_out_valid) begin
        info_word = {info_word[5:0], info_out_bit};
        if (info_out_last) info_q.push_back(info_word);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Sends bits w[14] .. w[15-nb]; leaves in_valid high for the caller.
  task automatic send_bits(input logic [14:0] w, input int nb, input logic corr);
    for (int i = 14; i > 14 - nb; i--) begin
      logic accepted;
      int   tries;
      in_valid       = 1'b1;
      in_bit         = w[i];
      correct_errors = corr;
      accepted       = 1'b0;
      tries          = 0;
      while (!accepted && tries < 200) begin
        @(negedge clk);
        accepted = in_ready;
        if (!accepted) stall_cnt++;
        @(posedge clk);
        #1;
        tries++;
      end
      if (!accepted) check("in_accept", {31'd0, accepted}, 32'd1);
      last_acc = cyc;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int t = 0;
    while (got_q.size() < n && t < 600) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("word_count", got_q.size(), n);
  endtask

  task automatic check_word(input string tag, input logic [14:0] exp);
    if (got_q.size() > 0) check(tag, got_q.pop_front(), {17'd0, exp});
    else check(tag, 32'hDEAD, {17'd0, exp});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_bit"},   {31'd0, out_bit},   32'd0);
    check({tag, "_out_last"},  {31'd0, out_last},  32'd0);
    check({tag, "_err_count"}, {28'd0, err_count}, 32'd0);
    check({tag, "_out_fail"},  {31'd0, out_fail},  32'd0);
    check({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Clean codeword c(x) = g(x).
    send_bits(15'h01D1, 15, 1'b1);
    idle();
    wait_words(1);
    check("t1_len", len_q.size() > 0 ? len_q[0] : 0, 32'd15);
    check("t1_latency", first_cyc_q.size() > 0 ? first_cyc_q[0] - last_acc : -1, 32'd1);
    check_word("t1_word", 15'h01D1);
    check("t1_err", {28'd0, err_count}, 32'd0);
    check("t1_fail", {31'd0, out_fail}, 32'd0);

    // Single error on the first digit.
    send_bits(15'h41D1, 15, 1'b1);
    idle();
    wait_words(1);
    check_word("t2_word", 15'h01D1);
    check("t2_err", {28'd0, err_count}, 32'd1);
    check("t2_fail", {31'd0, out_fail}, 32'd0);

    // Double error at e3 and e10.
    send_bits(15'h05D9, 15, 1'b1);
    idle();
    wait_words(1);
    check_word("t3_word", 15'h01D1);
    check("t3_err", {28'd0, err_count}, 32'd2);
    check("t3_fail", {31'd0, out_fail}, 32'd0);

    // Correction disabled: word passes unchanged and the x^14 syndrome remains.
    send_bits(15'h41D1, 15, 1'b0);
    idle();
    wait_words(1);
    check_word("t4_word", 15'h41D1);
    check("t4_err", {28'd0, err_count}, 32'd0);
    check("t4_fail", {31'd0, out_fail}, 32'd1);

    // Three back-to-back words at full rate.
    got_q.delete();
    last_cyc_q.delete();
    info_q.delete();
    stall_cnt = 0;
    send_bits(15'h01D1, 15, 1'b1);
    send_bits(15'h41D1, 15, 1'b1);
    send_bits(15'h01D1, 15, 1'b1);
    idle();
    wait_words(3);
    check("t5_no_stall", stall_cnt, 32'd0);
    check_word("t5_word0", 15'h01D1);
    check_word("t5_word1", 15'h01D1);
    check_word("t5_word2", 15'h01D1);
    check("t5_gap01", last_cyc_q.size() == 3 ? last_cyc_q[1] - last_cyc_q[0] : 0, 32'd15);
    check("t5_gap12", last_cyc_q.size() == 3 ? last_cyc_q[2] - last_cyc_q[1] : 0, 32'd15);
    check("t5_info_count", info_q.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t5_info%0d", i), info_q.size() > i ? {25'd0, info_q[i]} : 32'hDEAD, 32'h01);

    // Sink stalls for 20 cycles while three words arrive.
    got_q.delete();
    stall_cnt = 0;
    fork
      begin
        send_bits(15'h01D1, 15, 1'b1);
        send_bits(15'h05D9, 15, 1'b1);
        send_bits(15'h41D1, 15, 1'b1);
        idle();
      end
      begin
        repeat (12) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_words(3);
    check("t6_in_ready_drop", {31'd0, stall_cnt > 0}, 32'd1);
    check_word("t6_word0", 15'h01D1);
    check_word("t6_word1", 15'h01D1);
    check_word("t6_word2", 15'h01D1);
    check("t6_err", {28'd0, err_count}, 32'd1);

    // Reset in the middle of a load discards the partial word.
    got_q.delete();
    send_bits(15'h41D1, 7, 1'b1);
    idle();
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    send_bits(15'h41D1, 15, 1'b1);
    idle();
    wait_words(1);
    check_word("t7_word", 15'h01D1);
    check("t7_err", {28'd0, err_count}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
